// File: rtl/gray_to_binary_tracker.sv
// Two-stage Gray-to-binary decoder for samples arriving from another count domain.
// It also classifies each step against the previous sample as up, down or illegal.
module gray_to_binary_tracker #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] g_in,
  input  logic             g_valid,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  output logic             up,
  output logic             down,
  output logic             step_err,
  output logic [ERRW-1:0]  err_cnt
);

  localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1);
  localparam logic [ERRW-1:0]  CNT_ONE  = ERRW'(1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic [WIDTH-1:0] g_q, g_d;
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] b_out_q, b_out_d;
  logic             b_valid_q, b_valid_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             step_err_q, step_err_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] delta;

  always_comb begin
    // Stage 1: capture the raw Gray sample
    g_d  = g_valid ? g_in : g_q;
    v1_d = g_valid;

    // Stage 2: decode and classify; b_out_q doubles as the previous decoded sample
    b_out_d    = b_out_q;
    b_valid_d  = v1_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    step_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    primed_d   = primed_q;
    delta      = '0;
    if (v1_q) begin
      b_out_d = gray2bin(g_q);
      delta   = b_out_d - b_out_q;
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (delta == '0) begin
        up_d = 1'b0;
      end else if (delta == STEP_ONE) begin
        up_d = 1'b1;
      end else if (&delta) begin
        down_d = 1'b1;
      end else begin
        step_err_d = 1'b1;
        err_cnt_d  = sat_inc(err_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q        <= '0;
      v1_q       <= 1'b0;
      b_out_q    <= '0;
      b_valid_q  <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
      primed_q   <= 1'b0;
    end else begin
      g_q        <= g_d;
      v1_q       <= v1_d;
      b_out_q    <= b_out_d;
      b_valid_q  <= b_valid_d;
      up_q       <= up_d;
      down_q     <= down_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
      primed_q   <= primed_d;
    end
  end

  assign b_out    = b_out_q;
  assign b_valid  = b_valid_q;
  assign up       = up_q;
  assign down     = down_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Scoreboard bench for gray_to_binary_tracker (WIDTH=4, ERRW=2 so saturation is reachable).
// Directed sequences from the test plan followed by randomized traffic with resets.
module tb_gray_to_binary_tracker;

  localparam int WIDTH = 4;
  localparam int ERRW  = 2;
  localparam int MODV  = 1 << WIDTH;
  localparam int CMAX  = (1 << ERRW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] g_in = '0;
  logic             g_valid = 1'b0;
  logic [WIDTH-1:0] b_out;
  logic             b_valid, up, down, step_err;
  logic [ERRW-1:0]  err_cnt;

  gray_to_binary_tracker #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .g_in(g_in), .g_valid(g_valid),
    .b_out(b_out), .b_valid(b_valid), .up(up), .down(down),
    .step_err(step_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int b;
    bit up;
    bit down;
    bit err;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // reference model state
  bit m_primed = 0;
  int m_prev = 0;
  int m_cnt = 0;
  // values the DUT should hold between pulses
  int hold_b = 0;
  int hold_cnt = 0;

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int bin_of(input int g);
    for (int v = 0; v < MODV; v++) if (gray_of(v) == g) return v;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic send(input int g);
    exp_t e;
    int d;
    @(negedge clk);
    rst = 1'b0; g_valid = 1'b1; g_in = WIDTH'(g);
    e.due = cyc + 2;
    e.b = bin_of(g);
    e.up = 0; e.down = 0; e.err = 0;
    if (m_primed) begin
      d = (e.b - m_prev + MODV) % MODV;
      if (d == 1) e.up = 1;
      else if (d == MODV - 1) e.down = 1;
      else if (d != 0) begin
        e.err = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
    m_primed = 1;
    m_prev = e.b;
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; g_valid = 1'b0; g_in = WIDTH'($urandom_range(0, MODV - 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; g_valid = 1'b1; g_in = WIDTH'($urandom_range(0, MODV - 1));
    q.delete();
    m_primed = 0; m_prev = 0; m_cnt = 0;
    hold_b = 0; hold_cnt = 0;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (b_valid) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          checks++; failures++;
          $display("FAIL unexpected_b_valid at cycle %0d: b_out=%0d queued=%0d", cyc, b_out, q.size());
        end else begin
          e = q.pop_front();
          check("b_out", int'(b_out), e.b);
          check("up", int'(up), int'(e.up));
          check("down", int'(down), int'(e.down));
          check("step_err", int'(step_err), int'(e.err));
          check("err_cnt", int'(err_cnt), e.cnt);
          hold_b = e.b;
          hold_cnt = e.cnt;
        end
      end else begin
        if (q.size() > 0 && q[0].due == cyc) begin
          checks++; failures++;
          $display("FAIL missing_b_valid at cycle %0d: b_valid=0 expected 1 for b_out=%0d", cyc, q[0].b);
          void'(q.pop_front());
        end
        check("idle_flags", int'({up, down, step_err}), 0);
        check("hold_b_out", int'(b_out), hold_b);
        check("hold_err_cnt", int'(err_cnt), hold_cnt);
      end
    end
  end

  initial begin
    int r, cur;
    do_reset();
    do_reset();

    // exhaustive decode, counting up
    for (int v = 0; v < MODV; v++) send(gray_of(v));
    idle(3);

    // wrap and direction
    do_reset();
    send(4'b1000); send(4'b0000); send(4'b1000); send(4'b1001);
    idle(3);

    // illegal jump and resync
    do_reset();
    send(4'b0000); send(4'b0011); send(4'b0010);
    idle(3);

    // hold and gaps
    do_reset();
    send(4'b0110); idle(3); send(4'b0110); send(4'b0111);
    idle(3);

    // saturation of the error counter
    do_reset();
    for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 4'b0000 : 4'b0110);
    idle(3);

    // reset while a sample is in stage 1
    do_reset();
    send(4'b0000);
    idle(2);
    send(4'b0011);
    do_reset();
    send(4'b1000);
    idle(3);

    // randomized traffic
    cur = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      cur = (cur + 1) % MODV;
      else if (r < 60) cur = (cur + MODV - 1) % MODV;
      else if (r < 70) cur = cur;
      else if (r < 82) cur = $urandom_range(0, MODV - 1);
      if (r >= 97) do_reset();
      else if (r >= 88) idle($urandom_range(1, 3));
      else send(gray_of(cur));
    end
    idle(4);

    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
